// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift scheduler.
package shift_sched_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned ID_W   = 3;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SHIFT2 = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/shift_scheduler_if.sv
// Request/response bundle between issue logic (master) and the scheduler (slave).
interface shift_scheduler_if
    import shift_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [AMT_W*N_REQ-1:0]  req_amt;
    logic [2*N_REQ-1:0]      req_op;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_W-1:0]       resp_data;
    logic [ID_W-1:0]         resp_id;

    modport master (
        output req_valid, req_data, req_amt, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/barrelshifter32.sv
// Shared 32-bit barrel shifter: aluc[1:0] 00 SRA, 01 SRL, 1x SLL; aluc[2] bypasses.
module barrelshifter32 (
    input  logic [31:0] a,
    input  logic [5:0]  b,
    input  logic [2:0]  aluc,
    output logic [31:0] c
);

    // Shift selection; amounts of 32 and above flush to fill bits.
    always_comb begin
        case (aluc[1:0])
            2'b00:   c = $signed(a) >>> b;
            2'b01:   c = a >> b;
            default: c = a << b;
        endcase
        if (aluc[2]) begin
            c = a;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap.
module rr_arbiter
    import shift_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    int unsigned pos;

    // Walk candidates from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        grant_idx = '0;
        grant     = '0;
        pos       = 0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            pos = 32'(last_grant) + 32'(k);
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (valid[IDX_W'(pos)]) begin
                grant_idx = ID_W'(pos);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant[i] = (|valid) && (grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin front end sequencing the single shared barrel shifter.
// Build option: SHIFT_SCHED_ROTATE_EN makes op 11 a two-pass rotate-left;
// without it op 11 is a plain SLL.
module shift_scheduler
    import shift_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    shift_scheduler_if.slave  bus
);

    state_t              state;
    logic [ID_W-1:0]     last_grant;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;

    logic [DATA_W-1:0]   sel_data;
    logic [AMT_W-1:0]    sel_amt;
    logic [1:0]          sel_op;

    logic [DATA_W-1:0]   op_data;
    logic [AMT_W-1:0]    op_amt;
    logic [1:0]          op_op;
    logic [ID_W-1:0]     op_id;

    logic [AMT_W-1:0]    sh_amt;
    logic [1:0]          sh_op;
    logic [DATA_W-1:0]   sh_out;

    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [ID_W-1:0]     resp_id_q;

`ifdef SHIFT_SCHED_ROTATE_EN
    logic [DATA_W-1:0]   rot_tmp;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Only the granted requester sees ready, and only while idle and out of reset.
    always_comb begin
        bus.req_ready = (!rst && state == IDLE) ? grant : '0;
        accept        = |(bus.req_valid & bus.req_ready);
    end

    // Pick the granted requester's payload.
    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        sel_op   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.req_data[i*DATA_W +: DATA_W];
                sel_amt  = sel_amt  | bus.req_amt[i*AMT_W +: AMT_W];
                sel_op   = sel_op   | bus.req_op[i*2 +: 2];
            end
        end
    end

    // Shifter controls derive from the operand registers only.
    always_comb begin
        sh_amt = op_amt;
        sh_op  = op_op;
`ifdef SHIFT_SCHED_ROTATE_EN
        if (state == SHIFT2) begin
            sh_amt = AMT_W'(DATA_W - 32'(op_amt));
            sh_op  = OP_SRL;
        end
`endif
    end

    barrelshifter32 u_shifter (
        .a    (op_data),
        .b    ({1'b0, sh_amt}),
        .aluc ({1'b0, sh_op}),
        .c    (sh_out)
    );

    // Scheduler FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= ID_W'(N_REQ - 1);
            op_data      <= '0;
            op_amt       <= '0;
            op_op        <= '0;
            op_id        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
`ifdef SHIFT_SCHED_ROTATE_EN
            rot_tmp      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_data    <= sel_data;
                        op_amt     <= sel_amt;
                        op_op      <= sel_op;
                        op_id      <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef SHIFT_SCHED_ROTATE_EN
                    if (op_op == OP_ROL && op_amt != '0) begin
                        rot_tmp <= sh_out;
                        state   <= SHIFT2;
                    end else begin
                        resp_data_q  <= sh_out;
                        resp_id_q    <= op_id;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
`else
                    resp_data_q  <= sh_out;
                    resp_id_q    <= op_id;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
`endif
                end
`ifdef SHIFT_SCHED_ROTATE_EN
                SHIFT2: begin
                    resp_data_q  <= sh_out | rot_tmp;
                    resp_id_q    <= op_id;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
`endif
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Scoreboard bench for shift_scheduler; honours SHIFT_SCHED_ROTATE_EN if defined.
`timescale 1ns/1ps
module tb_shift_scheduler;
    import shift_sched_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_scheduler_if #(.N_REQ(N)) bus ();

    shift_scheduler #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no/unexpected event, want the specified event (cycle %0d)", name, cyc);
    endtask

    // Reference result of one request, straight from the op definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input logic [1:0] op);
        case (op)
            2'b00:   return $signed(d) >>> amt;
            2'b01:   return d >> amt;
            2'b10:   return d << amt;
            default: begin
`ifdef SHIFT_SCHED_ROTATE_EN
                if (amt == 0) return d;
                return (d << amt) | (d >> (32 - amt));
`else
                return d << amt;
`endif
            end
        endcase
    endfunction

    function automatic int ref_latency(input int amt, input logic [1:0] op);
`ifdef SHIFT_SCHED_ROTATE_EN
        if (op == 2'b11 && amt != 0) return 2;
`endif
        return 1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       sbq[$];
    int         resp_cyc_q[$];
    logic [2:0] resp_id_q[$];

    // Monitor: grant model, latency, stability and response scoreboard.
    int          m_last = N - 1;
    bit          busy   = 0;
    bit          prev_rv = 0;
    bit          hold_v = 0;
    logic [31:0] hold_d;
    logic [2:0]  hold_id;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] hsv;
        int           p;
        exp_t         e;
        if (rst) begin
            check("ready_in_reset", 32'(bus.req_ready), 32'(0));
            sbq.delete();
            busy    = 0;
            m_last  = N - 1;
            prev_rv = 0;
            hold_v  = 0;
        end else begin
            exp_rdy = '0;
            if (!busy) begin
                p = rr_pick(bus.req_valid, m_last);
                if (p >= 0) exp_rdy[p] = 1'b1;
            end
            check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

            if (bus.resp_valid && !prev_rv) begin
                if (sbq.size() == 0) fail_evt("spurious_resp");
                else check("resp_latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
            end
            if (hold_v) begin
                check("hold_valid", 32'(bus.resp_valid), 32'(1));
                check("hold_data", bus.resp_data, hold_d);
                check("hold_id", 32'(bus.resp_id), 32'(hold_id));
            end
            hold_v  = bus.resp_valid && !bus.resp_ready;
            hold_d  = bus.resp_data;
            hold_id = bus.resp_id;

            if (bus.resp_valid && bus.resp_ready) begin
                if (sbq.size() == 0) begin
                    fail_evt("resp_no_expect");
                end else begin
                    e = sbq.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_id", 32'(bus.resp_id), 32'(e.id));
                end
                busy = 0;
                resp_cyc_q.push_back(cyc);
                resp_id_q.push_back(bus.resp_id);
            end

            hsv = bus.req_valid & bus.req_ready;
            if (|hsv) begin
                p = 0;
                for (int i = 0; i < N; i++) if (hsv[i]) p = i;
                e.id   = 3'(p);
                e.data = ref_shift(bus.req_data[p*32 +: 32], int'(bus.req_amt[p*5 +: 5]), bus.req_op[p*2 +: 2]);
                e.acc  = cyc + 1;
                e.lat  = ref_latency(int'(bus.req_amt[p*5 +: 5]), bus.req_op[p*2 +: 2]);
                sbq.push_back(e);
                busy   = 1;
                m_last = p;
            end
            prev_rv = bus.resp_valid;
        end
    end

    task automatic rst_pulse();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
        bus.req_data[idx*32 +: 32] = d;
        bus.req_amt[idx*5 +: 5]    = a;
        bus.req_op[idx*2 +: 2]     = o;
        bus.req_valid[idx]         = 1'b1;
    endtask

    // Issue one request and return right after its accept edge.
    task automatic send(input int idx, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
        bit ok = 0;
        set_req(idx, d, a, o);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus.req_ready[idx];
            @(posedge clk); #1;
        end
        bus.req_valid[idx] = 1'b0;
        if (!ok) fail_evt("send_timeout");
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.resp_valid) lat = k;
        end
        if (lat < 0) fail_evt("resp_timeout");
    endtask

`ifdef SHIFT_SCHED_ROTATE_EN
    localparam int NT = 5;
    logic [31:0] t_exp [5] = '{32'h0C3961E0, 32'h0F0C3961, 32'hFF0C3961, 32'h0C3961EF, 32'hF0C3961E};
    int          t_lat [5] = '{1, 1, 1, 2, 1};
`else
    localparam int NT = 4;
    logic [31:0] t_exp [5] = '{32'h0C3961E0, 32'h0F0C3961, 32'hFF0C3961, 32'h0C3961E0, 32'h0};
    int          t_lat [5] = '{1, 1, 1, 1, 1};
`endif
    logic [1:0]  t_op  [5] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11};
    logic [4:0]  t_amt [5] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        logic [N-1:0] hs;

        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_data   = '0;
        bus.req_amt    = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;

        // Reset values, with all requesters asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_resp_id", 32'(bus.resp_id), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // Directed single-pass and op 11 cases from requester 0.
        bus.resp_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            send(0, 32'hF0C3961E, t_amt[i], t_op[i]);
            wait_resp(lat);
            check("dir_latency", 32'(lat), 32'(t_lat[i]));
            check("dir_data", bus.resp_data, t_exp[i]);
            check("dir_id", 32'(bus.resp_id), 32'(0));
            @(posedge clk); #1;
        end

        // Fairness: all requesters hold valid after a fresh reset.
        rst_pulse();
        for (int i = 0; i < N; i++) set_req(i, 32'h8000_0001 + 32'(i) * 32'h1111_1111, 5'(i + 1), 2'($urandom_range(0, 2)));
        base = resp_cyc_q.size();
        for (int t = 0; t < 60 && resp_cyc_q.size() < base + 5; t++) begin
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        if (resp_cyc_q.size() < base + 5) begin
            fail_evt("fair_timeout");
        end else begin
            for (int k = 0; k < 5; k++) begin
                check("fair_id", 32'(resp_id_q[base + k]), 32'(k % N));
                if (k > 0) check("fair_gap", 32'(resp_cyc_q[base + k] - resp_cyc_q[base + k - 1]), 32'(3));
            end
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure: response held 10 cycles while others wait.
        bus.resp_ready = 1'b0;
        send(1, 32'h1234_5678, 5'd7, 2'b01);
        set_req(2, 32'hDEAD_BEEF, 5'd3, 2'b10);
        set_req(3, 32'h0BAD_F00D, 5'd9, 2'b00);
        wait_resp(lat);
        repeat (10) begin
            @(negedge clk);
            check("bp_req_ready", 32'(bus.req_ready), 32'(0));
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_before", 32'(bus.resp_valid), 32'(1));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_valid_after", 32'(bus.resp_valid), 32'(0));
        repeat (4) @(posedge clk); #1;

        // Reset in SHIFT drops the operation; next grant restarts at requester 0.
        send(2, 32'hCAFE_0001, 5'd2, 2'b10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(bus.resp_valid), 32'(0));
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 32'h0000_00F0 + 32'(i), 5'd1, 2'b01);
        @(negedge clk);
        check("midrst_grant0", 32'(bus.req_ready), 32'(1));
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(posedge clk); #1;

        // Randomized traffic with random consumer stalls.
        hs = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 2'($urandom));
                    else
                        bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sbq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_scheduler.md
# shift_scheduler

Arbitrated front end for the shared 32-bit barrel shifter. It accepts shift requests from up to 8 independent requesters over valid/ready handshakes and grants one request at a time in round-robin order. It sequences the single `barrelshifter32` instance and returns each result with the requester's ID over a valid/ready response channel. It sits between the ALU-side issue logic and the shifter datapath.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept; at most one bit high.
- `req_data`  in  32*N_REQ: operand; slice i belongs to requester i.
- `req_amt`  in  5*N_REQ: shift amount 0..31.
- `req_op`  in  2*N_REQ: 00 SRA, 01 SRL, 10 SLL, 11 SLL (or ROL, see Configuration).
- `resp_valid`  out  1: result valid.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_data`  out  32: shifted result.
- `resp_id`  out  3: index of the requester that owns the result.

## Operation
- The FSM has four states:
  - `IDLE`: no operation in progress.
  - `SHIFT`: first shifter pass.
  - `SHIFT2`: second shifter pass; only used when rotate support is compiled in.
  - `RESP`: result held for the consumer.
- In `IDLE`, the arbiter picks the first requester with `req_valid` set, searching from `last_grant+1` upward with wrap-around. Only that requester's `req_ready` is driven high. All `req_ready` bits are 0 in any other state.
- On a request handshake (valid and ready both high, in `IDLE`):
  - latch data, amount, op and ID into operand registers;
  - set `last_grant` to the granted index;
  - move to `SHIFT`.
- The shifter's `a`, `b` and `aluc` inputs are driven only from the operand registers. `b[5]` is tied to 0, `aluc[2]` to 0, and `aluc[1:0]` comes from the op.
- In `SHIFT`:
  - ops 00, 01 and 10: register the shifter output into `resp_data`, set `resp_valid`, move to `RESP`;
  - op 11: behaviour is set by the build option (see Configuration).
- In `RESP`, `resp_data`, `resp_id` and `resp_valid` hold steady until `resp_ready` is high. On that handshake, clear `resp_valid` and return to `IDLE`.
- A requester that drops `req_valid` before it is granted is simply skipped. There is no request queueing.

## Timing
- Reset values:
  - all `req_ready` = 0 during reset;
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0;
  - state = `IDLE`;
  - `last_grant` = N_REQ-1, so requester 0 has highest priority first.
- `req_ready` is combinational from `req_valid` and `last_grant` while in `IDLE`.
- Latency is counted from the accept edge E0:
  - `resp_valid` goes high after E1 for single-pass ops;
  - after E2 for ROL.
- With `resp_ready` held high:
  - a single-pass op's response handshake completes at E2;
  - the next accept happens at E3 at the earliest;
  - throughput is therefore 1 op per 3 cycles, or 1 per 4 cycles for ROL.
- Reset asserted mid-operation drops the in-flight operation. Outputs return to their reset values on the next edge. No response is emitted for the dropped operation.
- `resp_ready` held low: the block stalls in `RESP` indefinitely and accepts no new request.

## Configuration
- Macro: `SHIFT_SCHED_ROTATE_EN`.
- Defined: op 11 is rotate-left (ROL), done in two shifter passes:
  - `SHIFT` stores SLL(data, amt) in a temporary register;
  - `SHIFT2` runs SRL(data, 32-amt) and ORs it with the temporary into `resp_data`;
  - if amt is 0, `SHIFT2` is skipped and `resp_data` = data, so latency is the same as a single-pass op.
- Undefined: op 11 executes as SLL. Neither `SHIFT2` nor the temporary register exists.

## Structure
- Package `shift_sched_pkg` holds:
  - op encodings `OP_SRA`, `OP_SRL`, `OP_SLL`, `OP_ROL`;
  - the FSM state type;
  - `DATA_W` = 32, `AMT_W` = 5, `ID_W` = 3.
- Sub-module `rr_arbiter` provides the combinational N_REQ-way round-robin grant. Its inputs are the valid vector and `last_grant`. Its outputs are a one-hot grant and the granted index.
- The existing `barrelshifter32` is instantiated once and is not modified.

## Test plan
- **Single-pass ops.** Reset, then requester 0 sends data 0xF0C3961E, amt 4:
  - op 10 returns `resp_data` 0x0C3961E0, `resp_id` 0;
  - op 01 returns 0x0F0C3961;
  - op 00 returns 0xFF0C3961;
  - `resp_valid` rises exactly one cycle after accept.
- **Fairness.** All 4 requesters hold valid continuously with `resp_ready` = 1. Grants go 0, 1, 2, 3, 0. Responses appear every 3 cycles, with `resp_id` matching the grant order.
- **Backpressure.** Hold `resp_ready` = 0 for 10 cycles after `resp_valid` rises:
  - `resp_data` and `resp_id` stay stable;
  - all `req_ready` bits stay 0;
  - the response handshake completes on the first cycle `resp_ready` = 1.
- **ROL build** (`SHIFT_SCHED_ROTATE_EN` defined):
  - data 0xF0C3961E, amt 4, op 11 returns 0x0C3961EF two cycles after accept;
  - amt 0 returns 0xF0C3961E one cycle after accept.
- **ROL compiled out:** the same op 11, amt 4 request returns 0x0C3961E0.
- **Reset mid-op:** assert `rst` for one cycle while in `SHIFT`. No response is emitted. `resp_valid` stays 0. The next grant goes to requester 0.
